// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues word reads over req/ack, buffers one
// word under decode back-pressure and discards in-flight data on redirects.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic [31:0] o_pc_out
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_FLUSH} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_flush_addr, r_inst, r_pc_out, r_hold_buf, r_hold_pc;
    logic        r_inst_valid;
    logic        w_out_free, w_ack;

    assign w_out_free   = !r_inst_valid || !i_stall;
    // ack is ignored in HOLD, where no request is outstanding
    assign w_ack        = (r_state != S_HOLD) && i_imem_ack;
    assign o_imem_req   = !i_rst && (r_state != S_HOLD);
    assign o_imem_addr  = (r_state == S_FLUSH) ? r_flush_addr : r_pc;
    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_pc_out     = r_pc_out;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_REQ;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (i_redirect_valid) w_state_nxt = w_ack ? S_REQ : S_FLUSH;
                else if (w_ack && !w_out_free) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (i_redirect_valid || !i_stall) w_state_nxt = S_REQ;
            end
            S_FLUSH: begin
                if (w_ack) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= RESET_PC;
            r_flush_addr <= '0;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_pc_out     <= '0;
            r_hold_buf   <= '0;
            r_hold_pc    <= '0;
        end else if (i_redirect_valid) begin
            r_pc         <= {i_redirect_pc[31:2], 2'b00};
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
            // remember the address the memory is still working on
            if (r_state == S_REQ && !w_ack) r_flush_addr <= r_pc;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_ack) begin
                        r_pc <= r_pc + 32'(PC_STEP);
                        if (w_out_free) begin
                            r_inst       <= i_imem_rdata;
                            r_pc_out     <= r_pc;
                            r_inst_valid <= 1'b1;
                        end else begin
                            r_hold_buf <= i_imem_rdata;
                            r_hold_pc  <= r_pc;
                        end
                    end else if (w_out_free && r_inst_valid) begin
                        r_inst_valid <= 1'b0;
                        r_inst       <= NOP_INST;
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        r_inst       <= r_hold_buf;
                        r_pc_out     <= r_hold_pc;
                        r_inst_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table for streaming/stall/redirect,
// plus hand sequences for mid-operation reset and PC wrap.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, redir, ack;
    logic [31:0] rpc;
    logic        req0, req1, vld0, vld1;
    logic [31:0] addr0, addr1, inst0, inst1, pco0, pco1, rdata0, rdata1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rdata0 = addr0 ^ 32'hA5A5_0000;
    assign rdata1 = addr1 ^ 32'hA5A5_0000;

    inst_fetch dut0 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_redirect_valid(redir),
        .i_redirect_pc(rpc), .o_imem_req(req0), .o_imem_addr(addr0),
        .i_imem_ack(ack), .i_imem_rdata(rdata0), .o_inst(inst0),
        .o_inst_valid(vld0), .o_pc_out(pco0)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_redirect_valid(redir),
        .i_redirect_pc(rpc), .o_imem_req(req1), .o_imem_addr(addr1),
        .i_imem_ack(ack), .i_imem_rdata(rdata1), .o_inst(inst1),
        .o_inst_valid(vld1), .o_pc_out(pco1)
    );

    typedef struct {
        logic        stall, ack, redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst, e_pc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic s, logic a, logic r, logic [31:0] rp, logic eq,
                                logic [31:0] ea, logic ev, logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.stall = s; v.ack = a; v.redir = r; v.rpc = rp;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // drive on negedge, sample 1 time unit after the following posedge
    task automatic step(input logic s, input logic a, input logic r, input logic [31:0] rp);
        @(negedge clk);
        stall = s; ack = a; redir = r; rpc = rp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0; ack = 1'b0; rpc = '0;

        // reset
        repeat (3) step(0, 0, 0, 0);
        chk("rst req", {31'b0, req0}, 32'd0);
        chk("rst valid", {31'b0, vld0}, 32'd0);
        chk("rst inst", inst0, 32'h13);
        chk("rst pc_out", pco0, 32'h0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rel req", {31'b0, req0}, 32'd1);
        chk("rel addr", addr0, 32'h0);
        chk("rel valid", {31'b0, vld0}, 32'd0);
        chk("rel inst", inst0, 32'h13);

        // stream, back-pressure, redirect in flight, redirect+ack+stall, redirect in HOLD
        tv.push_back(mk(0,1,0,0,     1,32'h4,  1,32'hA5A5_0000,32'h0));
        tv.push_back(mk(0,1,0,0,     1,32'h8,  1,32'hA5A5_0004,32'h4));
        tv.push_back(mk(0,1,0,0,     1,32'hC,  1,32'hA5A5_0008,32'h8));
        repeat (5) tv.push_back(mk(1,1,0,0, 0,32'h0, 1,32'hA5A5_0008,32'h8));
        tv.push_back(mk(0,1,0,0,     1,32'h10, 1,32'hA5A5_000C,32'hC));
        tv.push_back(mk(0,1,0,0,     1,32'h14, 1,32'hA5A5_0010,32'h10));
        tv.push_back(mk(0,0,0,0,     1,32'h14, 0,32'h13,0));
        tv.push_back(mk(0,0,0,0,     1,32'h14, 0,32'h13,0));
        tv.push_back(mk(0,0,1,32'h200, 1,32'h14, 0,32'h13,0));
        tv.push_back(mk(0,0,0,0,     1,32'h14, 0,32'h13,0));
        tv.push_back(mk(0,0,0,0,     1,32'h14, 0,32'h13,0));
        tv.push_back(mk(0,1,0,0,     1,32'h200,0,32'h13,0));
        tv.push_back(mk(0,1,0,0,     1,32'h204,1,32'hA5A5_0200,32'h200));
        tv.push_back(mk(1,1,1,32'h41, 1,32'h40, 0,32'h13,0));
        tv.push_back(mk(0,1,0,0,     1,32'h44, 1,32'hA5A5_0040,32'h40));
        tv.push_back(mk(1,1,0,0,     0,32'h0,  1,32'hA5A5_0040,32'h40));
        tv.push_back(mk(1,1,1,32'h100, 1,32'h100,0,32'h13,0));
        tv.push_back(mk(0,1,0,0,     1,32'h104,1,32'hA5A5_0100,32'h100));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].stall, tv[i].ack, tv[i].redir, tv[i].rpc);
            chk($sformatf("v%0d req", i), {31'b0, req0}, {31'b0, tv[i].e_req});
            if (tv[i].e_req) chk($sformatf("v%0d addr", i), addr0, tv[i].e_addr);
            chk($sformatf("v%0d valid", i), {31'b0, vld0}, {31'b0, tv[i].e_valid});
            chk($sformatf("v%0d inst", i), inst0, tv[i].e_inst);
            if (tv[i].e_valid) chk($sformatf("v%0d pc_out", i), pco0, tv[i].e_pc);
        end

        // reset while in HOLD
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("hold entered req", {31'b0, req0}, 32'd0);
        @(negedge clk); rst = 1'b1;
        step(1, 1, 0, 0);
        chk("hold-rst valid", {31'b0, vld0}, 32'd0);
        chk("hold-rst inst", inst0, 32'h13);
        @(negedge clk); rst = 1'b0; stall = 1'b0; ack = 1'b0; #1;
        chk("hold-rst req", {31'b0, req0}, 32'd1);
        chk("hold-rst addr", addr0, 32'h0);

        // reset while in FLUSH, stale ack in the reset cycle
        step(0, 0, 1, 32'h300);
        chk("flush addr", addr0, 32'h0);
        chk("flush req", {31'b0, req0}, 32'd1);
        @(negedge clk); rst = 1'b1;
        step(0, 1, 0, 0);
        chk("flush-rst valid", {31'b0, vld0}, 32'd0);
        @(negedge clk); rst = 1'b0; ack = 1'b0; #1;
        chk("flush-rst addr", addr0, 32'h0);
        step(0, 1, 0, 0);
        chk("flush-rst pc_out", pco0, 32'h0);
        chk("flush-rst inst", inst0, 32'hA5A5_0000);
        chk("flush-rst next addr", addr0, 32'h4);

        // PC wrap from RESET_PC=FFFF_FFF8, then redirect+ack+stall together
        @(negedge clk); rst = 1'b1;
        step(0, 0, 0, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("wrap rst addr", addr1, 32'hFFFF_FFF8);
        step(0, 1, 0, 0);
        chk("wrap0 pc_out", pco1, 32'hFFFF_FFF8);
        chk("wrap0 inst", inst1, 32'h5A5A_FFF8);
        step(0, 1, 0, 0);
        chk("wrap1 pc_out", pco1, 32'hFFFF_FFFC);
        chk("wrap1 inst", inst1, 32'h5A5A_FFFC);
        chk("wrap1 addr", addr1, 32'h0);
        step(0, 1, 0, 0);
        chk("wrap2 pc_out", pco1, 32'h0);
        chk("wrap2 inst", inst1, 32'hA5A5_0000);
        chk("wrap2 valid", {31'b0, vld1}, 32'd1);
        step(1, 1, 1, 32'h41);
        chk("rsa addr", addr1, 32'h40);
        chk("rsa valid", {31'b0, vld1}, 32'd0);
        chk("rsa inst", inst1, 32'h13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
